alu_seq: RTL

Parametrised multi-cycle ALU for the MIPS datapath: a registered successor to the single-cycle ALU. It adds XOR, NOR, signed/unsigned compare, an iterative unsigned multiply and an optional iterative unsigned divide. All operations use one start/done handshake, and results stay registered until the next accepted operation. It sits in the execute stage; the control unit stalls the pipeline while Busy is high.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_iter.sv | 115 +++++++++++
 rtl/alu_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM state type and default widths for alu_seq
//    Optional feature macro: ALU_DIV_EN (enables DIVU in alu_iter/alu_seq)
package alu_pkg;

   localparam int CTRL_W_DEF = 4;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - start/done request bus between execute-stage control and alu_seq
//    master: Start, SrcA, SrcB, Control out; Busy, Done, Result, Hi, Zero, DivZero in
//    slave : mirror of master
interface alu_seq_if #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
);
   logic              Start;
   logic [WIDTH-1:0]  SrcA;
   logic [WIDTH-1:0]  SrcB;
   logic [CTRL_W-1:0] Control;
   logic              Busy;
   logic              Done;
   logic [WIDTH-1:0]  Result;
   logic [WIDTH-1:0]  Hi;
   logic              Zero;
   logic              DivZero;

   modport master (
      output Start, SrcA, SrcB, Control,
      input  Busy, Done, Result, Hi, Zero, DivZero
   );

   modport slave (
      input  Start, SrcA, SrcB, Control,
      output Busy, Done, Result, Hi, Zero, DivZero
   );
endinterface

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - one-bit-per-cycle shift-add multiplier and (ALU_DIV_EN) restoring divider
//    clk, reset    : clock, synchronous active-high reset
//    start_i       : load operands, counter = WIDTH-1
//    op_div_i      : (ALU_DIV_EN only) 1 = DIVU, 0 = MULU
//    a_i, b_i      : operands
//    last_o        : current cycle performs the final step
//    lo_o, hi_o    : values after the current step (product lo/hi, quotient/remainder)
module alu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
`ifdef ALU_DIV_EN
   input  logic             op_div_i,
`endif
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);
   localparam int CW = $clog2(WIDTH);

   // hi_q is the product high word / partial remainder; lo_q holds the
   // multiplier being shifted out (product low bits shift in) or the
   // dividend being shifted out (quotient bits shift in).
   logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d;
   logic [WIDTH-1:0] step_lo, step_hi;
   logic [WIDTH:0]   mul_sum;

   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      step_hi = mul_sum[WIDTH:1];
   end

`ifdef ALU_DIV_EN
   logic             div_q, div_d;
   logic [WIDTH:0]   div_shl, div_diff;
   logic [WIDTH-1:0] div_lo, div_hi;

   // Zero divisor never borrows, so the quotient fills with ones and the
   // remainder ends up holding the dividend.
   always_comb begin
      div_shl  = {hi_q, lo_q[WIDTH-1]};
      div_diff = div_shl - {1'b0, b_q};
      if (!div_diff[WIDTH]) begin
         div_hi = div_diff[WIDTH-1:0];
         div_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         div_hi = div_shl[WIDTH-1:0];
         div_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
   end

   assign lo_o = div_q ? div_lo : step_lo;
   assign hi_o = div_q ? div_hi : step_hi;
`else
   assign lo_o = step_lo;
   assign hi_o = step_hi;
`endif

   assign last_o = run_q && (cnt_q == '0);

   always_comb begin
      lo_d  = lo_q;
      hi_d  = hi_q;
      b_d   = b_q;
      cnt_d = cnt_q;
      run_d = run_q;
`ifdef ALU_DIV_EN
      div_d = div_q;
`endif
      if (start_i) begin
         lo_d  = a_i;
         hi_d  = '0;
         b_d   = b_i;
         cnt_d = CW'(WIDTH - 1);
         run_d = 1'b1;
`ifdef ALU_DIV_EN
         div_d = op_div_i;
`endif
      end else if (run_q) begin
         lo_d  = lo_o;
         hi_d  = hi_o;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == '0) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lo_q  <= '0;
         hi_q  <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
`ifdef ALU_DIV_EN
         div_q <= 1'b0;
`endif
      end else begin
         lo_q  <= lo_d;
         hi_q  <= hi_d;
         b_q   <= b_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
`ifdef ALU_DIV_EN
         div_q <= div_d;
`endif
      end
   end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle execute-stage ALU with start/done handshake
//    clk, reset : clock, synchronous active-high reset
//    bus        : alu_seq_if.slave (Start/SrcA/SrcB/Control in; Busy/Done/Result/Hi/Zero/DivZero out)
//    Optional feature macro: ALU_DIV_EN (DIVU support; otherwise DIVU is an unsupported code)
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic      clk,
   input  logic      reset,
   alu_seq_if.slave  bus
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
   logic             zero_q, zero_d, divz_q, divz_d;
   logic             run_div_q, run_div_d, bz_q, bz_d;

   logic [WIDTH-1:0] sc_res;
   logic             is_mul, is_div, is_iter, accept;
   logic             iter_last;
   logic [WIDTH-1:0] iter_lo, iter_hi;

   assign is_mul = (bus.Control == CTRL_W'(OP_MULU));
`ifdef ALU_DIV_EN
   assign is_div = (bus.Control == CTRL_W'(OP_DIVU));
`else
   assign is_div = 1'b0;
`endif
   assign is_iter = is_mul || is_div;
   assign accept  = bus.Start && (state_q != RUN);

   // Unsupported codes (and DIVU without the divider) fall through to 0.
   always_comb begin
      sc_res = '0;
      case (bus.Control)
         CTRL_W'(OP_AND):  sc_res = bus.SrcA & bus.SrcB;
         CTRL_W'(OP_OR):   sc_res = bus.SrcA | bus.SrcB;
         CTRL_W'(OP_ADD):  sc_res = bus.SrcA + bus.SrcB;
         CTRL_W'(OP_XOR):  sc_res = bus.SrcA ^ bus.SrcB;
         CTRL_W'(OP_NOR):  sc_res = ~(bus.SrcA | bus.SrcB);
         CTRL_W'(OP_SLTU): sc_res = WIDTH'(bus.SrcA < bus.SrcB);
         CTRL_W'(OP_SUB):  sc_res = bus.SrcA - bus.SrcB;
         CTRL_W'(OP_SLT):  sc_res = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
         default:          sc_res = '0;
      endcase
   end

   alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .reset    (reset),
      .start_i  (accept && is_iter),
`ifdef ALU_DIV_EN
      .op_div_i (is_div),
`endif
      .a_i      (bus.SrcA),
      .b_i      (bus.SrcB),
      .last_o   (iter_last),
      .lo_o     (iter_lo),
      .hi_o     (iter_hi)
   );

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      hi_d      = hi_q;
      zero_d    = zero_q;
      divz_d    = divz_q;
      run_div_d = run_div_q;
      bz_d      = bz_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               if (is_iter) begin
                  state_d   = RUN;
                  run_div_d = is_div;
                  bz_d      = (bus.SrcB == '0);
               end else begin
                  state_d  = DONE;
                  result_d = sc_res;
                  hi_d     = '0;
                  zero_d   = (sc_res == '0);
                  divz_d   = 1'b0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (iter_last) begin
               state_d  = DONE;
               result_d = iter_lo;
               hi_d     = iter_hi;
               zero_d   = (iter_lo == '0);
               divz_d   = run_div_q && bz_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         result_q  <= '0;
         hi_q      <= '0;
         zero_q    <= 1'b0;
         divz_q    <= 1'b0;
         run_div_q <= 1'b0;
         bz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         hi_q      <= hi_d;
         zero_q    <= zero_d;
         divz_q    <= divz_d;
         run_div_q <= run_div_d;
         bz_q      <= bz_d;
      end
   end

   assign bus.Busy    = (state_q == RUN);
   assign bus.Done    = (state_q == DONE);
   assign bus.Result  = result_q;
   assign bus.Hi      = hi_q;
   assign bus.Zero    = zero_q;
   assign bus.DivZero = divz_q;
endmodule
